// File: rtl/fp_div_pkg.sv
// fp_div_pkg: shared types and constants for the floating-point divide
// scheduler.
//   state_e  : controller states (IDLE, CHECK, DIVIDE, NORM, DONE)
//   BIAS     : IEEE-754 single-precision exponent bias
//   ITER     : number of quotient bits produced by the mantissa divider
//   QNAN     : result returned for 0/0
//   INF_EXP  : exponent field used for the divide-by-zero infinity result
package fp_div_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_DIVIDE,
    ST_NORM,
    ST_DONE
  } state_e;

  localparam int          BIAS    = 127;
  localparam int          ITER    = 25;
  localparam logic [31:0] QNAN    = 32'hFFC0_0000;
  localparam logic [7:0]  INF_EXP = 8'hFF;

endpackage

// File: rtl/mant_div_iter.sv
// mant_div_iter: restoring mantissa divider, one quotient bit per clock,
// MSB first. A start pulse loads the operands; the following ITER clocks
// each shift one bit into the quotient. Bit 24 of the quotient is the
// integer bit, bits 23..0 the fraction; the result is truncated.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   start           load dd_mant/ds_mant and begin iterating
//   dd_mant/ds_mant 24-bit mantissas with hidden bit ({1, frac})
//   quot            25-bit quotient (complete once done has been seen)
//   done            high during the cycle whose edge produces the last bit
module mant_div_iter
  import fp_div_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] dd_mant,
  input  logic [23:0] ds_mant,
  output logic [24:0] quot,
  output logic        done
);

  // Partial remainder stays below 2*divisor < 2^25 before each shift.
  logic [25:0] rem_q, rem_d;
  logic [23:0] div_q, div_d;
  logic [24:0] quot_q, quot_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        run_q, run_d;
  logic [25:0] diff;

  always_comb begin
    rem_d  = rem_q;
    div_d  = div_q;
    quot_d = quot_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    diff   = rem_q - {2'b00, div_q};
    if (start) begin
      rem_d  = {2'b00, dd_mant};
      div_d  = ds_mant;
      quot_d = '0;
      cnt_d  = '0;
      run_d  = 1'b1;
    end else if (run_q) begin
      if (rem_q >= {2'b00, div_q}) begin
        rem_d  = {diff[24:0], 1'b0};
        quot_d = {quot_q[23:0], 1'b1};
      end else begin
        rem_d  = {rem_q[24:0], 1'b0};
        quot_d = {quot_q[23:0], 1'b0};
      end
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == 5'(ITER - 1)) begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q  <= '0;
      div_q  <= '0;
      quot_q <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      div_q  <= div_d;
      quot_q <= quot_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
    end
  end

  assign quot = quot_q;
  assign done = run_q && (cnt_q == 5'(ITER - 1));

endmodule

// File: rtl/fp_div_scheduler.sv
// fp_div_scheduler: shares one iterative IEEE-754 single-precision divider
// between two requesters (A and B).
// Arbitration: fixed priority A over B by default; define
// FPDIV_ROUND_ROBIN_EN to alternate between requesters on contention.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   req_a_valid/req_b_valid    requester has an operation pending
//   req_a_ready/req_b_ready    operation accepted at this edge (IDLE only)
//   req_x_dd/req_x_ds          dividend / divisor
//   res_valid/res_ready        result handshake
//   res_out, res_id            quotient, originating requester (0=A, 1=B)
//   res_exception/res_zero_div divide-by-zero flags
//   busy                       controller not in IDLE
module fp_div_scheduler
  import fp_div_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_a_valid,
  input  logic        req_b_valid,
  output logic        req_a_ready,
  output logic        req_b_ready,
  input  logic [31:0] req_a_dd,
  input  logic [31:0] req_a_ds,
  input  logic [31:0] req_b_dd,
  input  logic [31:0] req_b_ds,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_out,
  output logic        res_id,
  output logic        res_exception,
  output logic        res_zero_div,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [31:0] dd_q, dd_d;
  logic [31:0] ds_q, ds_d;
  logic        id_q, id_d;
  logic [31:0] res_out_q, res_out_d;
  logic        res_id_q, res_id_d;
  logic        exc_q, exc_d;
  logic        zdiv_q, zdiv_d;
`ifdef FPDIV_ROUND_ROBIN_EN
  // High when B was not the last requester served.
  logic        prio_b_q, prio_b_d;
`endif

  logic        grant_b;
  logic        idle;
  logic        accept;
  logic        div_start;
  logic        div_done;
  logic [24:0] quot;
  logic        sign;
  logic [7:0]  exp_raw;

  mant_div_iter u_mant_div (
    .clk     (clk),
    .reset   (reset),
    .start   (div_start),
    .dd_mant ({1'b1, dd_q[22:0]}),
    .ds_mant ({1'b1, ds_q[22:0]}),
    .quot    (quot),
    .done    (div_done)
  );

`ifdef FPDIV_ROUND_ROBIN_EN
  assign grant_b = req_b_valid & (~req_a_valid | prio_b_q);
`else
  assign grant_b = req_b_valid & ~req_a_valid;
`endif

  assign idle        = (state_q == ST_IDLE);
  assign req_a_ready = idle & req_a_valid & ~grant_b;
  assign req_b_ready = idle & grant_b;
  assign accept      = req_a_ready | req_b_ready;

  // Exponent wraps modulo 256; range errors are deliberately not handled.
  assign sign    = dd_q[31] ^ ds_q[31];
  assign exp_raw = dd_q[30:23] - ds_q[30:23] + 8'(BIAS);

  always_comb begin
    state_d   = state_q;
    dd_d      = dd_q;
    ds_d      = ds_q;
    id_d      = id_q;
    res_out_d = res_out_q;
    res_id_d  = res_id_q;
    exc_d     = exc_q;
    zdiv_d    = zdiv_q;
    div_start = 1'b0;
`ifdef FPDIV_ROUND_ROBIN_EN
    prio_b_d  = prio_b_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          dd_d    = grant_b ? req_b_dd : req_a_dd;
          ds_d    = grant_b ? req_b_ds : req_a_ds;
          id_d    = grant_b;
          state_d = ST_CHECK;
`ifdef FPDIV_ROUND_ROBIN_EN
          prio_b_d = ~grant_b;
`endif
        end
      end
      ST_CHECK: begin
        if (ds_q == 32'd0) begin
          res_out_d = (dd_q == 32'd0) ? QNAN : {sign, INF_EXP, 23'd0};
          exc_d     = 1'b1;
          zdiv_d    = 1'b1;
          res_id_d  = id_q;
          state_d   = ST_DONE;
        end else if (dd_q == 32'd0) begin
          res_out_d = 32'd0;
          exc_d     = 1'b0;
          zdiv_d    = 1'b0;
          res_id_d  = id_q;
          state_d   = ST_DONE;
        end else begin
          div_start = 1'b1;
          state_d   = ST_DIVIDE;
        end
      end
      ST_DIVIDE: begin
        if (div_done) begin
          state_d = ST_NORM;
        end
      end
      ST_NORM: begin
        // Quotient of two [1,2) mantissas lies in (0.5,2): at most one
        // left shift is needed.
        if (quot[24]) begin
          res_out_d = {sign, exp_raw, quot[23:1]};
        end else begin
          res_out_d = {sign, exp_raw - 8'd1, quot[22:0]};
        end
        exc_d    = 1'b0;
        zdiv_d   = 1'b0;
        res_id_d = id_q;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      dd_q      <= '0;
      ds_q      <= '0;
      id_q      <= 1'b0;
      res_out_q <= '0;
      res_id_q  <= 1'b0;
      exc_q     <= 1'b0;
      zdiv_q    <= 1'b0;
`ifdef FPDIV_ROUND_ROBIN_EN
      prio_b_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      dd_q      <= dd_d;
      ds_q      <= ds_d;
      id_q      <= id_d;
      res_out_q <= res_out_d;
      res_id_q  <= res_id_d;
      exc_q     <= exc_d;
      zdiv_q    <= zdiv_d;
`ifdef FPDIV_ROUND_ROBIN_EN
      prio_b_q  <= prio_b_d;
`endif
    end
  end

  assign res_valid     = (state_q == ST_DONE);
  assign res_out       = res_out_q;
  assign res_id        = res_id_q;
  assign res_exception = exc_q;
  assign res_zero_div  = zdiv_q;
  assign busy          = ~idle;

endmodule

// File: tb/tb_fp_div_scheduler.sv
// tb_fp_div_scheduler: scoreboard bench for fp_div_scheduler. Accepted
// requests push the reference-model result into a queue; a monitor pops and
// compares on every new result. Directed cases, arbitration, backpressure,
// mid-divide reset and randomized traffic from both requesters.
module tb_fp_div_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_a_valid = 1'b0, req_b_valid = 1'b0;
  logic        req_a_ready, req_b_ready;
  logic [31:0] req_a_dd = '0, req_a_ds = '0, req_b_dd = '0, req_b_ds = '0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [31:0] res_out;
  logic        res_id, res_exception, res_zero_div, busy;

  fp_div_scheduler dut (
    .clk(clk), .reset(reset),
    .req_a_valid(req_a_valid), .req_b_valid(req_b_valid),
    .req_a_ready(req_a_ready), .req_b_ready(req_b_ready),
    .req_a_dd(req_a_dd), .req_a_ds(req_a_ds),
    .req_b_dd(req_b_dd), .req_b_ds(req_b_ds),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_out(res_out), .res_id(res_id),
    .res_exception(res_exception), .res_zero_div(res_zero_div),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        id;
    logic [31:0] out;
    logic        exc;
    logic        zdiv;
    int          due;
  } exp_t;

  exp_t sb[$];
  bit   acc_ids[$];
  bit   rec = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic prev_v = 1'b0;
  bit   rand_done;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: exact integer quotient of the scaled mantissas, truncated.
  function automatic exp_t model(input logic id, input logic [31:0] dd,
                                 input logic [31:0] ds, input int acc);
    exp_t        m;
    logic [47:0] num, den, qq;
    logic [24:0] q;
    logic [7:0]  e;
    logic        s;
    s = dd[31] ^ ds[31];
    m.id = id; m.exc = 1'b0; m.zdiv = 1'b0; m.due = acc + 1;
    if (ds == 0 && dd == 0) begin
      m.out = 32'hFFC00000; m.exc = 1'b1; m.zdiv = 1'b1;
    end else if (ds == 0) begin
      m.out = {s, 8'hFF, 23'd0}; m.exc = 1'b1; m.zdiv = 1'b1;
    end else if (dd == 0) begin
      m.out = 32'd0;
    end else begin
      num = {1'b1, dd[22:0], 24'd0};
      den = {24'd0, 1'b1, ds[22:0]};
      qq  = num / den;
      q   = qq[24:0];
      e   = dd[30:23] - ds[30:23] + 8'd127;
      if (q[24]) m.out = {s, e, q[23:1]};
      else       m.out = {s, e - 8'd1, q[22:0]};
      m.due = acc + 27;
    end
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Acceptance watcher: sampled mid-low-phase, acceptance at the next edge.
  always @(negedge clk) begin
    #2;
    if (!reset) begin
      if (req_a_valid && req_a_ready) begin
        sb.push_back(model(1'b0, req_a_dd, req_a_ds, cyc + 1));
        if (rec) acc_ids.push_back(1'b0);
      end
      if (req_b_valid && req_b_ready) begin
        sb.push_back(model(1'b1, req_b_dd, req_b_ds, cyc + 1));
        if (rec) acc_ids.push_back(1'b1);
      end
    end
  end

  // Monitor: each rising res_valid is a new result.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && res_valid && !prev_v) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_result actual=%h required=none", res_out);
      end else begin
        e = sb.pop_front();
        chk("res_out", res_out, e.out);
        chk("res_id", 32'(res_id), 32'(e.id));
        chk("res_exception", 32'(res_exception), 32'(e.exc));
        chk("res_zero_div", 32'(res_zero_div), 32'(e.zdiv));
        chk("latency_edge", cyc, e.due);
      end
    end
    prev_v = res_valid;
  end

  task automatic issue(input bit id, input logic [31:0] dd, input logic [31:0] ds);
    int n = 0;
    @(negedge clk);
    if (id) begin req_b_valid = 1'b1; req_b_dd = dd; req_b_ds = ds; end
    else    begin req_a_valid = 1'b1; req_a_dd = dd; req_a_ds = ds; end
    #1;
    while (!(id ? req_b_ready : req_a_ready)) begin
      n++;
      if (n > 2000) begin
        checks++; errors++;
        $display("FAIL accept_timeout actual=no_ready required=ready id=%0d", id);
        break;
      end
      @(negedge clk); #1;
    end
    @(negedge clk);
    if (id) req_b_valid = 1'b0; else req_a_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 1000) begin
      @(negedge clk); n++;
    end
    checks++;
    if (n >= 1000) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d_pending required=0", sb.size());
    end
  endtask

  task automatic rand_op(output logic [31:0] dd, output logic [31:0] ds);
    int r;
    r  = $urandom_range(0, 9);
    dd = $urandom;
    ds = $urandom;
    if (r == 0) ds = 32'd0;
    if (r == 1) dd = 32'd0;
    if (r == 2) begin dd = 32'd0; ds = 32'd0; end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit exp_ord[4];
    int n;
`ifdef FPDIV_ROUND_ROBIN_EN
    exp_ord = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_ord = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_res_out", res_out, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_flags", {30'd0, res_exception, res_zero_div}, 0);
    chk("rst_readies", {30'd0, req_a_ready, req_b_ready}, 0);
    @(negedge clk); reset = 1'b0;

    // Directed values and specials
    issue(1'b0, 32'h40C00000, 32'h40000000);
    drain();
    issue(1'b0, 32'h3F800000, 32'h40400000);
    issue(1'b1, 32'hC0A00000, 32'h40A00000);
    issue(1'b0, 32'h40A00000, 32'h00000000);
    issue(1'b1, 32'h00000000, 32'h00000000);
    issue(1'b0, 32'h00000000, 32'h40000000);
    drain();

    // Arbitration with both requesters held from reset
    @(negedge clk);
    reset = 1'b1;
    req_a_valid = 1'b1; req_a_dd = 32'h00000000; req_a_ds = 32'h40000000;
    req_b_valid = 1'b1; req_b_dd = 32'h40A00000; req_b_ds = 32'h00000000;
    acc_ids.delete(); rec = 1'b1;
    repeat (2) @(negedge clk);
    sb.delete(); reset = 1'b0;
    n = 0;
    while (acc_ids.size() < 4 && n < 500) begin @(negedge clk); n++; end
    req_a_valid = 1'b0; req_b_valid = 1'b0; rec = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i < acc_ids.size()) chk("arb_order", 32'(acc_ids[i]), 32'(exp_ord[i]));
      else chk("arb_order_missing", 32'(acc_ids.size()), 32'(i + 1));
    end
    drain();

    // Backpressure: result held in DONE, no new acceptance
    res_ready = 1'b0;
    issue(1'b0, 32'h3F800000, 32'h40400000);
    n = 0;
    while (!res_valid && n < 100) begin @(negedge clk); n++; end
    req_a_valid = 1'b1; req_a_dd = 32'h40C00000; req_a_ds = 32'h40000000;
    req_b_valid = 1'b1; req_b_dd = 32'h00000000; req_b_ds = 32'h40000000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      chk("hold_res_out", res_out, 32'h3EAAAAAA);
      chk("hold_res_valid", 32'(res_valid), 1);
      chk("hold_readies", {30'd0, req_a_ready, req_b_ready}, 0);
    end
    req_b_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk); #1;
    chk("release_busy", 32'(busy), 0);
    chk("release_ready_a", 32'(req_a_ready), 1);
    @(negedge clk);
    req_a_valid = 1'b0;
    drain();

    // Reset in the middle of a divide
    issue(1'b0, 32'h40C00000, 32'h40000000);
    repeat (12) @(negedge clk);
    reset = 1'b1; #1;
    chk("midrst_res_valid", 32'(res_valid), 0);
    chk("midrst_res_out", res_out, 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_flags", {30'd0, res_exception, res_zero_div}, 0);
    sb.delete();
    @(negedge clk); reset = 1'b0;
    issue(1'b0, 32'h3F800000, 32'h40400000);
    drain();

    // Randomized traffic from both requesters with random backpressure
    rand_done = 1'b0;
    fork
      begin
        fork
          for (int i = 0; i < 20; i++) begin
            logic [31:0] a, b;
            rand_op(a, b);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(1'b0, a, b);
          end
          for (int j = 0; j < 20; j++) begin
            logic [31:0] c, d;
            rand_op(c, d);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(1'b1, c, d);
          end
        join
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(negedge clk);
          res_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    res_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
